recv_unit: RTL and testbench

RECV_UNIT -- requirements
Module: recv_unit

---
 rtl/pu_pkg.sv | 16 +
 rtl/recv_fifo.sv | 60 ++++++
 rtl/recv_unit.sv | 133 +++++++++++++
 tb/tb_recv_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_pkg.sv
// Shared types and header field positions for the receive unit.
package pu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } recv_state_t;

  localparam int HDR_SIZE_MSB = 15;
  localparam int HDR_SIZE_LSB = 8;
  localparam int HDR_BASE_MSB = 7;
  localparam int HDR_BASE_LSB = 0;

endpackage

// File: rtl/recv_fifo.sv
// Small synchronous FIFO buffering payload words between sender and data memory.
module recv_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/recv_unit.sv
// Receives a SEND transfer (header + payload) and writes it into data memory.
// Optional RECV_BOUNDS_EN adds DM_TOP address bounding with a sticky err flag.
module recv_unit
  import pu_pkg::*;
#(
  parameter int DW    = 16,
  parameter int AW    = 8,
  parameter int DEPTH = 4
`ifdef RECV_BOUNDS_EN
  , parameter int DM_TOP = (1 << AW) - 1
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          dm_gnt,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wd,
  output logic          busy,
  output logic          done,
  output logic          err
);

  recv_state_t   state_q, state_d;
  logic [7:0]    rem_q, rem_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic          ready_c;
  logic          push, pop;
  logic          fifo_full, fifo_empty;
  logic [DW-1:0] fifo_head;
  logic [7:0]    hdr_size;
  logic [AW-1:0] hdr_base;
  logic          addr_ok;

  assign hdr_size = in_data[HDR_SIZE_MSB:HDR_SIZE_LSB];
  assign hdr_base = AW'(in_data[HDR_BASE_MSB:HDR_BASE_LSB]);
  assign pop      = ~fifo_empty & dm_gnt;

  recv_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    wptr_d  = wptr_q;
    ready_c = 1'b0;
    push    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    if (pop) wptr_d = wptr_q + 1'b1;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (in_valid) begin
          wptr_d  = hdr_base;
          rem_d   = hdr_size;
          state_d = (hdr_size == 8'd0) ? DONE : DATA;
        end
      end
      DATA: begin
        busy    = 1'b1;
        ready_c = ~fifo_full;
        if (in_valid && !fifo_full) begin
          push  = 1'b1;
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = ~fifo_empty;
        if (fifo_empty) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake is blocked while reset is held even though the state already reads IDLE.
  assign in_ready = ready_c & ~rst;
  assign dm_addr  = wptr_q;
  assign dm_wd    = fifo_empty ? '0 : fifo_head;
  assign dm_we    = pop & addr_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      wptr_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wptr_q  <= wptr_d;
    end
  end

`ifdef RECV_BOUNDS_EN
  localparam logic [AW-1:0] DM_TOP_A = AW'(DM_TOP);

  logic err_q, err_d;

  // Out-of-range words are still popped so the transfer drains normally.
  assign addr_ok = (wptr_q <= DM_TOP_A);
  assign err     = err_q;

  always_comb begin
    err_d = err_q;
    if (pop && !addr_ok) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`else
  assign addr_ok = 1'b1;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_recv_unit.sv
// Directed self-checking bench for recv_unit; define RECV_BOUNDS_EN to exercise bounding.
module tb_recv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        dm_gnt = 1'b0;
  logic        dm_we;
  logic [7:0]  dm_addr;
  logic [15:0] dm_wd;
  logic        busy, done, err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int acc_cyc = -1;
  logic [7:0]  wa_q [$];
  logic [15:0] wd_q [$];

  always #5 clk = ~clk;

  recv_unit #(
    .DW(16), .AW(8), .DEPTH(4)
`ifdef RECV_BOUNDS_EN
    , .DM_TOP(8'h7F)
`endif
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dm_gnt(dm_gnt), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd),
    .busy(busy), .done(done), .err(err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (dm_we) begin
        wa_q.push_back(dm_addr);
        wd_q.push_back(dm_wd);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic send(input logic [15:0] w, input string nm);
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s: handshake timeout, in_ready=%b required 1", nm, in_ready);
    in_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_write(input int idx, input logic [7:0] a, input logic [15:0] d, input string nm);
    checks++;
    if (idx >= wa_q.size()) begin
      errors++;
      $display("FAIL %s: write %0d missing, got %0d writes", nm, idx, wa_q.size());
    end else if (wa_q[idx] !== a || wd_q[idx] !== d) begin
      errors++;
      $display("FAIL %s: write %0d got %h:%h required %h:%h", nm, idx, wa_q[idx], wd_q[idx], a, d);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, dm_we, dm_addr, dm_wd, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b we=%b addr=%h wd=%h busy=%b done=%b err=%b required all 0",
               in_ready, dm_we, dm_addr, dm_wd, busy, done, err);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    clear_log();
    dm_gnt = 1'b1;
    send(16'h0310, "basic_hdr");
    send(16'h00A1, "basic_w1");
    send(16'h00A2, "basic_w2");
    send(16'h00A3, "basic_w3");
    wait_cycles(10);
    checks++;
    if (wa_q.size() != 3) begin
      errors++;
      $display("FAIL basic_count: writes=%0d required 3", wa_q.size());
    end
    check_write(0, 8'h10, 16'h00A1, "basic_wr0");
    check_write(1, 8'h11, 16'h00A2, "basic_wr1");
    check_write(2, 8'h12, 16'h00A3, "basic_wr2");
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done pulses=%0d busy=%b required 1 and 0", done_cnt, busy);
    end
  endtask

  task automatic test_zero_size();
    clear_log();
    send(16'h0020, "zero_hdr");
    wait_cycles(6);
    checks++;
    if (wa_q.size() != 0) begin
      errors++;
      $display("FAIL zero_no_write: writes=%0d required 0", wa_q.size());
    end
    checks++;
    if (done_cnt != 1 || done_cyc - acc_cyc < 0 || done_cyc - acc_cyc > 2) begin
      errors++;
      $display("FAIL zero_done: pulses=%0d delay=%0d required 1 pulse within 2 cycles",
               done_cnt, done_cyc - acc_cyc);
    end
  endtask

  task automatic test_stall();
    clear_log();
    dm_gnt = 1'b0;
    send(16'h0600, "stall_hdr");
    for (int i = 0; i < 4; i++) send(16'h00C0 + 16'(i), "stall_fill");
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || wa_q.size() != 0) begin
      errors++;
      $display("FAIL stall_full: in_ready=%b writes=%0d required 0 and 0", in_ready, wa_q.size());
    end
    wait_cycles(5);
    dm_gnt = 1'b1;
    send(16'h00C4, "stall_w5");
    send(16'h00C5, "stall_w6");
    wait_cycles(12);
    checks++;
    if (wa_q.size() != 6 || done_cnt != 1) begin
      errors++;
      $display("FAIL stall_count: writes=%0d done=%0d required 6 and 1", wa_q.size(), done_cnt);
    end
    for (int i = 0; i < 6; i++) check_write(i, 8'(i), 16'h00C0 + 16'(i), "stall_order");
  endtask

  task automatic test_wrap();
    clear_log();
    dm_gnt = 1'b1;
    send(16'h02FF, "wrap_hdr");
    send(16'h00B1, "wrap_w1");
    send(16'h00B2, "wrap_w2");
    wait_cycles(8);
    check_write(0, 8'hFF, 16'h00B1, "wrap_wr0");
    check_write(1, 8'h00, 16'h00B2, "wrap_wr1");
`ifndef RECV_BOUNDS_EN
    checks++;
    if (err !== 1'b0 || wa_q.size() != 2) begin
      errors++;
      $display("FAIL wrap_err: err=%b writes=%0d required 0 and 2", err, wa_q.size());
    end
`endif
  endtask

  task automatic test_reset_mid();
    clear_log();
    dm_gnt = 1'b0;
    send(16'h0540, "mid_hdr");
    send(16'h00D1, "mid_w1");
    send(16'h00D2, "mid_w2");
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_in_reset: in_ready=%b busy=%b required 0 and 0", in_ready, busy);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    dm_gnt = 1'b1;
    wait_cycles(8);
    checks++;
    if (wa_q.size() != 0 || done_cnt != 0) begin
      errors++;
      $display("FAIL mid_discard: writes=%0d done=%0d required 0 and 0", wa_q.size(), done_cnt);
    end
    send(16'h0150, "mid_new_hdr");
    send(16'h00E1, "mid_new_w1");
    wait_cycles(6);
    check_write(0, 8'h50, 16'h00E1, "mid_new_wr");
    checks++;
    if (done_cnt != 1 || wa_q.size() != 1) begin
      errors++;
      $display("FAIL mid_new_done: done=%0d writes=%0d required 1 and 1", done_cnt, wa_q.size());
    end
  endtask

`ifdef RECV_BOUNDS_EN
  task automatic test_bounds();
    clear_log();
    dm_gnt = 1'b1;
    send(16'h027F, "bnd_hdr");
    send(16'h00F1, "bnd_w1");
    send(16'h00F2, "bnd_w2");
    wait_cycles(8);
    checks++;
    if (wa_q.size() != 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL bnd_count: writes=%0d done=%0d required 1 and 1", wa_q.size(), done_cnt);
    end
    check_write(0, 8'h7F, 16'h00F1, "bnd_wr0");
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL bnd_err_set: err=%b required 1", err);
    end
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL bnd_err_clear: err=%b required 0", err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_size();
    test_stall();
    test_wrap();
    test_reset_mid();
`ifdef RECV_BOUNDS_EN
    test_bounds();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
